// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: stream source / memory side; slave: the loader itself.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: parses a framed byte stream (16-bit word count,
// little-endian payload words, XOR checksum), writes each word to instruction
// memory and keeps the core in reset until a load finishes with a good checksum.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_written
);

    localparam int unsigned Capacity = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH:0]   ww_q, ww_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                  accept;
    logic [15:0]           hdr_cnt;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            ww_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            ww_q        <= ww_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_hold     = 1'b1;
        unique case (state_q)
            StHdr0, StHdr1, StData, StCsum: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            StDone: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            StErr:   error = 1'b1;
            default: ;
        endcase
    end

    assign accept        = bus.in_valid && bus.in_ready;
    assign hdr_cnt       = {bus.in_data, cnt_q[7:0]};
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign words_written = ww_q;

    // Frame parser: next state, byte/word assembly, checksum and write pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        csum_d      = csum_q;
        ww_d        = ww_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StHdr0;
                    cnt_d      = '0;
                    byte_cnt_d = '0;
                    word_d     = '0;
                    csum_d     = '0;
                    ww_d       = '0;
                end
            end
            StHdr0: begin
                if (accept) begin
                    cnt_d[7:0] = bus.in_data;
                    csum_d     = csum_q ^ bus.in_data;
                    state_d    = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    cnt_d[15:8] = bus.in_data;
                    csum_d      = csum_q ^ bus.in_data;
                    if (32'(hdr_cnt) > Capacity) begin
                        state_d = StErr;
                    end else if (hdr_cnt == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d     = csum_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; the write lands next cycle.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ww_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {bus.in_data, word_q[23:0]};
                        word_d      = '0;
                        ww_d        = ww_q + 1'b1;
                        if (32'(ww_q) + 32'd1 == 32'(cnt_q)) begin
                            state_d = StCsum;
                        end
                    end else begin
                        word_d = word_q | (32'(bus.in_data) << {byte_cnt_q, 3'b000});
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (bus.in_data == csum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
